// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: control codes, FSM states and arbitration rule ids shared by the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int CTRL_W = 2;
  localparam logic [CTRL_W-1:0] CTRL_PASS     = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_STALL    = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE   = 2'b10;
  localparam logic [CTRL_W-1:0] CTRL_REDIRECT = 2'b11;
  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_e;
  typedef enum logic [2:0] {
    R_RESET, R_DCACHE, R_TRAP, R_BRANCH, R_WAIT, R_LOAD_USE, R_IMISS, R_PASS
  } rule_e;
  function automatic logic [CTRL_W-1:0] pc_code(input rule_e r);
    return (r == R_TRAP || r == R_BRANCH) ? CTRL_REDIRECT : (r == R_PASS) ? CTRL_PASS : CTRL_STALL;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_pattern_gen.sv
// hazard_pattern_gen: maps the winning arbitration rule to the per-register control code vector
module hazard_pattern_gen
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE    = 4,
  parameter int EX_STAGE  = 2,
  parameter int MEM_STAGE = 3
) (
  input  rule_e                     rule_i,
  output logic [CTRL_W*NSTAGE-1:0]  ctrl_stage_o
);
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    assign ctrl_stage_o[CTRL_W*k +: CTRL_W] =
      (rule_i == R_RESET || rule_i == R_TRAP) ? CTRL_BUBBLE :
      (rule_i == R_DCACHE) ? ((k < MEM_STAGE) ? CTRL_STALL : (k == MEM_STAGE) ? CTRL_BUBBLE : CTRL_PASS) :
      (rule_i == R_BRANCH) ? ((k < EX_STAGE) ? CTRL_BUBBLE : CTRL_PASS) :
      (rule_i == R_WAIT || rule_i == R_IMISS) ? ((k == 0) ? CTRL_BUBBLE : CTRL_PASS) :
      (rule_i == R_LOAD_USE) ? ((k == 0) ? CTRL_STALL : (k == EX_STAGE - 1) ? CTRL_BUBBLE : CTRL_PASS) :
      CTRL_PASS;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: arbitrates stalls, flushes and redirects for the PC and pipeline registers
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE       = 4,
  parameter int EX_STAGE     = 2,
  parameter int MEM_STAGE    = 3,
  parameter int ADDR_W       = 64,
  parameter int REDIRECT_LAT = 1,
  parameter int CNT_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_data_valid_i,
  input  logic                     dcache_busy_i,
  input  logic                     load_use_i,
  input  logic                     ex_branch_flag_i,
  input  logic [ADDR_W-1:0]        ex_pc_new_i,
  input  logic                     trap_req_i,
  input  logic [ADDR_W-1:0]        trap_vec_i,
  output logic [CTRL_W-1:0]        ctrl_pc_o,
  output logic [CTRL_W*NSTAGE-1:0] ctrl_stage_o,
  output logic [ADDR_W-1:0]        ctrl_to_pc_new_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
);
  localparam int HOLD_W = (REDIRECT_LAT > 1) ? $clog2(REDIRECT_LAT) : 1;
  if (EX_STAGE < 1 || MEM_STAGE <= EX_STAGE || MEM_STAGE >= NSTAGE || REDIRECT_LAT < 1) begin : g_bad_params
    $error("pipe_hazard_ctrl: illegal stage/latency parameters");
  end
  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    stall_q, stall_d, flush_q, flush_d;
  rule_e               rule;
  logic                redirect;
  // A branch seen in S_WAIT is ignored: EX only holds a bubble there.
  always_comb begin
    rule = rst ? R_RESET :
           dcache_busy_i ? R_DCACHE :
           trap_req_i ? R_TRAP :
           (ex_branch_flag_i && state_q == S_RUN) ? R_BRANCH :
           (state_q == S_WAIT) ? R_WAIT :
           load_use_i ? R_LOAD_USE :
           !icache_data_valid_i ? R_IMISS : R_PASS;
    redirect = (rule == R_TRAP) || (rule == R_BRANCH);
    ctrl_pc_o = pc_code(rule);
    ctrl_to_pc_new_o = (rule == R_RESET) ? '0 : (rule == R_TRAP) ? trap_vec_i : ex_pc_new_i;
    state_d = redirect ? S_WAIT :
              (rule == R_WAIT && hold_q == '0 && icache_data_valid_i) ? S_RUN : state_q;
    hold_d = redirect ? HOLD_W'(REDIRECT_LAT - 1) :
             (rule == R_WAIT && hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
    stall_d = stall_q + CNT_W'(ctrl_pc_o == CTRL_STALL);
    flush_d = flush_q + CNT_W'(redirect);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      hold_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
  hazard_pattern_gen #(
    .NSTAGE   (NSTAGE),
    .EX_STAGE (EX_STAGE),
    .MEM_STAGE(MEM_STAGE)
  ) u_pattern (
    .rule_i      (rule),
    .ctrl_stage_o(ctrl_stage_o)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a rule-table reference model
module tb_pipe_hazard_ctrl;
  localparam int NS = 4, EX = 2, MEM = 3, AW = 64, LAT = 2, CW = 8;
  localparam logic [1:0] P = 2'b00, S = 2'b01, B = 2'b10, R = 2'b11;
  logic clk = 0, rst = 1, ic = 0, dc = 0, lu = 0, br = 0, trap = 0;
  logic [AW-1:0] ex_pc = '0, tvec = '0;
  logic [1:0] pc_o;
  logic [2*NS-1:0] st_o;
  logic [AW-1:0] tg_o;
  logic [CW-1:0] stall_o, flush_o;
  int checks = 0, errors = 0;
  bit m_wait = 0;
  int m_hold = 0, m_stall = 0, m_flush = 0;

  pipe_hazard_ctrl #(.NSTAGE(NS), .EX_STAGE(EX), .MEM_STAGE(MEM), .ADDR_W(AW),
                     .REDIRECT_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .icache_data_valid_i(ic), .dcache_busy_i(dc), .load_use_i(lu),
    .ex_branch_flag_i(br), .ex_pc_new_i(ex_pc), .trap_req_i(trap), .trap_vec_i(tvec),
    .ctrl_pc_o(pc_o), .ctrl_stage_o(st_o), .ctrl_to_pc_new_o(tg_o),
    .stall_cnt_o(stall_o), .flush_cnt_o(flush_o));

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) assert (!(m_wait && br)) else $error("branch flag asserted while waiting");

  function automatic void model(output logic [1:0] epc, output logic [2*NS-1:0] est,
                                output logic [AW-1:0] etg, output bit nw, output int nh);
    int r;
    logic [1:0] c;
    nw = m_wait; nh = m_hold;
    r = rst ? 0 : dc ? 1 : trap ? 2 : (br && !m_wait) ? 3 : m_wait ? 4 : lu ? 5 : !ic ? 6 : 7;
    epc = (r == 2 || r == 3) ? R : (r == 7) ? P : S;
    etg = (r == 0) ? '0 : (r == 2) ? tvec : ex_pc;
    for (int k = 0; k < NS; k++) begin
      case (r)
        0, 2:    c = B;
        1:       c = (k < MEM) ? S : (k == MEM) ? B : P;
        3:       c = (k < EX) ? B : P;
        4, 6:    c = (k == 0) ? B : P;
        5:       c = (k == 0) ? S : (k == EX - 1) ? B : P;
        default: c = P;
      endcase
      est[2*k +: 2] = c;
    end
    if (r == 2 || r == 3) begin nw = 1; nh = LAT - 1; end
    else if (r == 4) begin
      if (nh != 0) nh--;
      else if (ic) nw = 0;
    end
  endfunction

  task automatic model_reset();
    m_wait = 0; m_hold = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input string nm);
    logic [1:0] epc;
    logic [2*NS-1:0] est;
    logic [AW-1:0] etg;
    bit nw;
    int nh;
    model(epc, est, etg, nw, nh);
    @(negedge clk);
    checks++; if (pc_o !== epc) begin errors++; $display("FAIL %s pc got %b exp %b", nm, pc_o, epc); end
    checks++; if (st_o !== est) begin errors++; $display("FAIL %s stages got %b exp %b", nm, st_o, est); end
    checks++; if (tg_o !== etg) begin errors++; $display("FAIL %s target got %h exp %h", nm, tg_o, etg); end
    checks++; if (stall_o !== CW'(m_stall)) begin errors++; $display("FAIL %s stall_cnt got %0d exp %0d", nm, stall_o, m_stall % 256); end
    checks++; if (flush_o !== CW'(m_flush)) begin errors++; $display("FAIL %s flush_cnt got %0d exp %0d", nm, flush_o, m_flush % 256); end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_stall = (m_stall + int'(epc == S)) % 256;
      m_flush = (m_flush + int'(epc == R)) % 256;
      m_wait = nw; m_hold = nh;
    end
    #1;
  endtask

  task automatic idle();
    dc = 0; lu = 0; br = 0; trap = 0; ic = 1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    step("reset0");
    step("reset1");
    rst = 0;
    step("run_after_reset");
  endtask

  task automatic test_branch();
    int f0;
    f0 = m_flush;
    idle(); br = 1; ex_pc = 64'h8000_0040;
    #1;
    checks++; if (st_o !== 8'b00001010) begin errors++; $display("FAIL branch_stages got %b exp 00001010", st_o); end
    step("branch");
    br = 0;
    step("branch_wait1");
    step("branch_wait2");
    step("branch_run");
    checks++; if (flush_o !== CW'(f0 + 1)) begin errors++; $display("FAIL branch_flush got %0d exp %0d", flush_o, f0 + 1); end
  endtask

  task automatic test_icache_miss_wait();
    int s0;
    idle(); br = 1; ex_pc = 64'h1234;
    step("miss_branch");
    br = 0; ic = 0;
    s0 = m_stall;
    for (int i = 0; i < 5; i++) step("miss_wait");
    ic = 1;
    step("miss_exit");
    checks++; if (stall_o !== CW'(s0 + 6)) begin errors++; $display("FAIL miss_stall got %0d exp %0d", stall_o, (s0 + 6) % 256); end
    step("miss_run");
  endtask

  task automatic test_dcache_busy();
    idle(); dc = 1; br = 1; ex_pc = 64'h8000_0040;
    #1;
    checks++; if (st_o !== 8'b10010101 || pc_o !== S) begin errors++; $display("FAIL dcache_pattern got %b/%b exp 10010101/01", st_o, pc_o); end
    for (int i = 0; i < 3; i++) step("dcache_busy");
    dc = 0;
    step("dcache_branch");
    br = 0;
    for (int i = 0; i < 3; i++) step("dcache_after");
  endtask

  task automatic test_trap_in_wait();
    idle(); br = 1; ex_pc = 64'h40;
    step("trap_branch");
    br = 0;
    step("trap_wait");
    trap = 1; tvec = 64'h100;
    #1;
    checks++; if (tg_o !== 64'h100 || st_o !== 8'hAA) begin errors++; $display("FAIL trap_out got %h/%b exp 100/10101010", tg_o, st_o); end
    step("trap_redirect");
    trap = 0;
    for (int i = 0; i < 3; i++) step("trap_reload");
  endtask

  task automatic test_load_use();
    idle(); lu = 1; ic = 0;
    #1;
    checks++; if (st_o !== 8'b00001001) begin errors++; $display("FAIL load_use_stages got %b exp 00001001", st_o); end
    step("load_use");
    lu = 0;
    step("imiss");
    idle();
  endtask

  task automatic test_reset_mid_wait();
    idle(); br = 1; ex_pc = 64'hBEEF;
    step("rst_branch");
    br = 0;
    #2 rst = 1;
    #1;
    checks++; if (pc_o !== S || st_o !== 8'hAA || tg_o !== '0) begin errors++; $display("FAIL rst_async got %b/%b/%h exp 01/10101010/0", pc_o, st_o, tg_o); end
    checks++; if (stall_o !== '0 || flush_o !== '0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", stall_o, flush_o); end
    model_reset();
    step("rst_hold");
    rst = 0;
    step("rst_released");
    checks++; if (pc_o !== P || st_o !== '0) begin errors++; $display("FAIL rst_run got %b/%b exp 00/0", pc_o, st_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      dc = ($urandom_range(0, 7) == 0);
      trap = ($urandom_range(0, 15) == 0);
      br = !m_wait && ($urandom_range(0, 4) == 0);
      lu = ($urandom_range(0, 4) == 0);
      ic = ($urandom_range(0, 3) != 0);
      ex_pc = {$urandom, $urandom};
      tvec = {$urandom, $urandom};
      step("random");
    end
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_branch();
    test_icache_miss_wait();
    test_dcache_busy();
    test_trap_in_wait();
    test_load_use();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
